// File: rtl/waveform_burst_player_if.sv
// Trigger/config/playback bundle between the trigger path (master)
// and the burst player (slave).
interface waveform_burst_player_if #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 16
);
   logic              Trig_Ctrl_Sin;
   logic [ADDR_W-1:0] Start_Addr_Vin;
   logic [ADDR_W-1:0] Stop_Addr_Vin;
   logic [CNT_W-1:0]  Burst_Num_Vin;
   logic [7:0]        Step_Div_Vin;
   logic [ADDR_W-1:0] Addr_Vout;
   logic              Rd_En_Sout;
   logic              Busy_Sout;
   logic              Ending_Sout;
   logic [CNT_W-1:0]  Cycle_Cnt_Vout;

   modport master (
      output Trig_Ctrl_Sin, Start_Addr_Vin, Stop_Addr_Vin, Burst_Num_Vin, Step_Div_Vin,
      input  Addr_Vout, Rd_En_Sout, Busy_Sout, Ending_Sout, Cycle_Cnt_Vout
   );

   modport slave (
      input  Trig_Ctrl_Sin, Start_Addr_Vin, Stop_Addr_Vin, Burst_Num_Vin, Step_Div_Vin,
      output Addr_Vout, Rd_En_Sout, Busy_Sout, Ending_Sout, Cycle_Cnt_Vout
   );
endinterface

// File: rtl/waveform_burst_player.sv
// Burst playback sequencer: on a trigger rising edge, steps waveform addresses
// Start..Stop for a programmed number of cycles, then pulses Ending.
module waveform_burst_player #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 16
) (
   input logic                    Clock,
   input logic                    Reset,
   waveform_burst_player_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t            state;
   logic              trig_d;
   logic [ADDR_W-1:0] start_lat;
   logic [ADDR_W-1:0] stop_lat;
   logic [CNT_W-1:0]  burst_lat;
   logic [7:0]        div_lat;
   logic [7:0]        div_cnt;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  cycle_cnt;
   logic              rd_en;
   logic              busy;
   logic              ending;

   // Config is latched at start so input changes mid-burst have no effect;
   // an abort (trigger low) outranks any address step or completion.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         trig_d    <= 1'b0;
         start_lat <= '0;
         stop_lat  <= '0;
         burst_lat <= '0;
         div_lat   <= '0;
         div_cnt   <= '0;
         addr      <= '0;
         cycle_cnt <= '0;
         rd_en     <= 1'b0;
         busy      <= 1'b0;
         ending    <= 1'b0;
      end else begin
         trig_d <= bus.Trig_Ctrl_Sin;
         ending <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Trig_Ctrl_Sin && !trig_d) begin
                  start_lat <= bus.Start_Addr_Vin;
                  stop_lat  <= bus.Stop_Addr_Vin;
                  burst_lat <= bus.Burst_Num_Vin;
                  div_lat   <= bus.Step_Div_Vin;
                  addr      <= bus.Start_Addr_Vin;
                  cycle_cnt <= '0;
                  div_cnt   <= '0;
                  rd_en     <= 1'b1;
                  busy      <= 1'b1;
                  state     <= PLAY;
               end
            end
            PLAY: begin
               if (!bus.Trig_Ctrl_Sin) begin
                  rd_en <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (div_cnt == div_lat) begin
                  div_cnt <= '0;
                  if (addr == stop_lat) begin
                     addr      <= start_lat;
                     cycle_cnt <= cycle_cnt + CNT_W'(1);
                     if ((burst_lat != '0) && ((cycle_cnt + CNT_W'(1)) == burst_lat)) begin
                        rd_en  <= 1'b0;
                        busy   <= 1'b0;
                        ending <= 1'b1;
                        state  <= DONE;
                     end
                  end else begin
                     addr <= addr + ADDR_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            DONE: begin
               if (!bus.Trig_Ctrl_Sin) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Addr_Vout      = addr;
   assign bus.Rd_En_Sout     = rd_en;
   assign bus.Busy_Sout      = busy;
   assign bus.Ending_Sout    = ending;
   assign bus.Cycle_Cnt_Vout = cycle_cnt;
endmodule

// File: tb/tb_waveform_burst_player.sv
// Bench for waveform_burst_player: directed and random bursts compared
// against an arithmetic model of the expected address/count timeline.
module tb_waveform_burst_player;
   localparam int ADDR_W = 14;
   localparam int CNT_W  = 16;
   localparam int AMOD   = 1 << ADDR_W;
   localparam int CMOD   = 1 << CNT_W;

   logic Clock = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   int   m_start;
   int   m_len;
   int   m_div;

   always #5 Clock = ~Clock;

   waveform_burst_player_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   waveform_burst_player #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Clock t counts from the first PLAY clock; each address lasts div+1 clocks.
   function automatic int exp_addr(input int t);
      return (m_start + (t / (m_div + 1)) % m_len) % AMOD;
   endfunction

   function automatic int exp_cnt(input int t);
      return (t / (m_len * (m_div + 1))) % CMOD;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input int start, input int stop, input int burst, input int div);
      bus.Start_Addr_Vin = ADDR_W'(start);
      bus.Stop_Addr_Vin  = ADDR_W'(stop);
      bus.Burst_Num_Vin  = CNT_W'(burst);
      bus.Step_Div_Vin   = 8'(div);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_quiet(input string tag, input int addr, input int cnt);
      check_output($sformatf("%s rd_en", tag), {31'd0, bus.Rd_En_Sout}, 0);
      check_output($sformatf("%s busy", tag), {31'd0, bus.Busy_Sout}, 0);
      check_output($sformatf("%s ending", tag), {31'd0, bus.Ending_Sout}, 0);
      check_output($sformatf("%s addr", tag), bus.Addr_Vout, addr);
      check_output($sformatf("%s cnt", tag), bus.Cycle_Cnt_Vout, cnt);
   endtask

   // abort_after=0 runs to completion; otherwise trigger drops after that many PLAY clocks.
   task automatic play(input string tag, input int start, input int stop, input int burst,
                       input int div, input int abort_after, input bit scramble);
      int total;
      int t_end;
      apply_stimulus(start, stop, burst, div);
      m_start = start;
      m_len   = (((stop - start) % AMOD) + AMOD) % AMOD + 1;
      m_div   = div;
      total   = burst * m_len * (div + 1);
      t_end   = (abort_after > 0) ? abort_after : total;
      bus.Trig_Ctrl_Sin = 1'b1;
      tick();
      for (int t = 0; t < t_end; t++) begin
         check_output($sformatf("%s t%0d addr", tag, t), bus.Addr_Vout, exp_addr(t));
         check_output($sformatf("%s t%0d rd_en", tag, t), {31'd0, bus.Rd_En_Sout}, 1);
         check_output($sformatf("%s t%0d busy", tag, t), {31'd0, bus.Busy_Sout}, 1);
         check_output($sformatf("%s t%0d ending", tag, t), {31'd0, bus.Ending_Sout}, 0);
         check_output($sformatf("%s t%0d cnt", tag, t), bus.Cycle_Cnt_Vout, exp_cnt(t));
         if (scramble && t == 2) begin
            bus.Stop_Addr_Vin  = ADDR_W'((stop + 6) % AMOD);
            bus.Start_Addr_Vin = ADDR_W'($urandom);
            bus.Burst_Num_Vin  = CNT_W'($urandom);
            bus.Step_Div_Vin   = 8'($urandom);
         end
         if (abort_after > 0 && t == t_end - 1) bus.Trig_Ctrl_Sin = 1'b0;
         tick();
      end
      if (abort_after > 0) begin
         check_quiet($sformatf("%s abort", tag), exp_addr(t_end - 1), exp_cnt(t_end - 1));
         tick();
         check_quiet($sformatf("%s idle", tag), exp_addr(t_end - 1), exp_cnt(t_end - 1));
      end else begin
         check_output($sformatf("%s end pulse", tag), {31'd0, bus.Ending_Sout}, 1);
         check_output($sformatf("%s end rd_en", tag), {31'd0, bus.Rd_En_Sout}, 0);
         check_output($sformatf("%s end busy", tag), {31'd0, bus.Busy_Sout}, 0);
         check_output($sformatf("%s end cnt", tag), bus.Cycle_Cnt_Vout, burst % CMOD);
         check_output($sformatf("%s end addr", tag), bus.Addr_Vout, start % AMOD);
         tick();
         check_quiet($sformatf("%s done", tag), start % AMOD, burst % CMOD);
         repeat (3) tick();
         check_quiet($sformatf("%s no restart", tag), start % AMOD, burst % CMOD);
         bus.Trig_Ctrl_Sin = 1'b0;
         tick();
         check_quiet($sformatf("%s idle", tag), start % AMOD, burst % CMOD);
      end
   endtask

   initial begin
      int start;
      int len;
      int div;
      int burst;
      int total;
      int abort_after;
      bit scramble;

      $display("[TB] waveform_burst_player bench start");
      Reset = 1'b1;
      bus.Trig_Ctrl_Sin = 1'b0;
      apply_stimulus(0, 0, 0, 0);
      repeat (2) tick();
      check_quiet("reset", 0, 0);
      Reset = 1'b0;
      tick();
      check_quiet("post reset", 0, 0);

      // Reset in the middle of a burst
      apply_stimulus(5, 9, 4, 1);
      bus.Trig_Ctrl_Sin = 1'b1;
      tick();
      check_output("mid start addr", bus.Addr_Vout, 5);
      repeat (5) tick();
      Reset = 1'b1;
      bus.Trig_Ctrl_Sin = 1'b0;
      tick();
      check_quiet("reset in play", 0, 0);
      Reset = 1'b0;
      tick();

      play("seq0_3", 0, 3, 2, 0, 0, 1'b0);
      play("single", 2, 2, 3, 2, 0, 1'b0);
      play("restart", 2, 2, 3, 2, 0, 1'b0);
      play("wrap", AMOD - 2, 1, 1, 0, 0, 1'b0);
      play("cont", 0, 1, 0, 0, 7, 1'b0);
      play("ignore in", 0, 3, 2, 0, 0, 1'b1);
      play("abort at end", 4, 6, 2, 1, 12, 1'b0);

      for (int i = 0; i < 8; i++) begin
         start    = int'($urandom_range(AMOD - 1, 0));
         len      = int'($urandom_range(6, 1));
         div      = int'($urandom_range(3, 0));
         burst    = int'($urandom_range(3, 1));
         total    = burst * len * (div + 1);
         abort_after = ($urandom_range(3, 0) == 0) ? int'($urandom_range(total, 1)) : 0;
         scramble = 1'($urandom_range(1, 0));
         play($sformatf("rnd%0d", i), start, (start + len - 1) % AMOD, burst, div, abort_after, scramble);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
